spi_cmd_sequencer: RTL and testbench

Register-driven SPI master that sequences complete command transactions (opcode, 24-bit address, 0-4 data bytes) to the on-board SPI memory model. Host software drives it through the PCIe/AXI slave register bank: slv_reg fields are the command inputs, and busy/done/rd_data are returned on slv_read. It replaces bit-level software control of spi_sck/spi_mosi/spi_ss with one start pulse per transaction. SPI mode 0, MSB first, single chip select.

---
 rtl/spi_cmd_sequencer_if.sv | 24 ++
 rtl/spi_cmd_sequencer.sv | 119 +++++++++++
 tb/tb_spi_cmd_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_sequencer_if.sv
// spi_cmd_sequencer_if: host command fields, status returns and SPI pins of the sequencer
interface spi_cmd_sequencer_if;
  logic        start;
  logic [7:0]  opcode;
  logic [23:0] addr;
  logic [31:0] wr_data;
  logic [2:0]  nbytes;
  logic        is_write;
  logic        busy;
  logic        done;
  logic [31:0] rd_data;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_ss_n;
  logic        spi_miso;
  modport master (
    output start, opcode, addr, wr_data, nbytes, is_write, spi_miso,
    input  busy, done, rd_data, spi_sck, spi_mosi, spi_ss_n
  );
  modport slave (
    input  start, opcode, addr, wr_data, nbytes, is_write, spi_miso,
    output busy, done, rd_data, spi_sck, spi_mosi, spi_ss_n
  );
endinterface

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: mode-0 SPI master running opcode + address + 0-4 data byte transactions
module spi_cmd_sequencer #(
  parameter int CLK_DIV    = 2,
  parameter int ADDR_BYTES = 3
) (
  input logic clk,
  input logic rst,
  spi_cmd_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_t;
  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [6:0] HDR    = 7'(8 * (1 + ADDR_BYTES));
  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [63:0] tx, tx_n;
  logic [31:0] rx, rx_n, rd, rd_n;
  logic [6:0]  idx, idx_n, bits, bits_n;
  logic        rd_op, rd_op_n, sck, sck_n, mosi, mosi_n, ss_n, ss_n_n, busy, busy_n, done, done_n;
  logic        tick;
  logic [2:0]  nb;
  assign tick = cnt == DIV_M1;
  assign nb   = bus.nbytes > 3'd4 ? 3'd4 : bus.nbytes;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.rd_data  = rd;
  assign bus.spi_sck  = sck;
  assign bus.spi_mosi = mosi;
  assign bus.spi_ss_n = ss_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      tx    <= '0;
      rx    <= '0;
      rd    <= '0;
      idx   <= '0;
      bits  <= '0;
      rd_op <= 1'b0;
      sck   <= 1'b0;
      mosi  <= 1'b0;
      ss_n  <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      tx    <= tx_n;
      rx    <= rx_n;
      rd    <= rd_n;
      idx   <= idx_n;
      bits  <= bits_n;
      rd_op <= rd_op_n;
      sck   <= sck_n;
      mosi  <= mosi_n;
      ss_n  <= ss_n_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = tick ? 8'd0 : cnt + 8'd1;
    tx_n    = tx;
    rx_n    = rx;
    rd_n    = rd;
    idx_n   = idx;
    bits_n  = bits;
    rd_op_n = rd_op;
    sck_n   = sck;
    mosi_n  = mosi;
    ss_n_n  = ss_n;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (bus.start) begin
          // reads shift out zeros in the data slot
          tx_n    = {bus.opcode, bus.addr, bus.is_write ? bus.wr_data : 32'd0};
          bits_n  = HDR + {1'b0, nb, 3'b000};
          rd_op_n = !bus.is_write;
          idx_n   = '0;
          rx_n    = '0;
          mosi_n  = bus.opcode[7];
          ss_n_n  = 1'b0;
          busy_n  = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: state_n = tick ? SHIFT_LO : SETUP;
      SHIFT_LO: if (tick) begin
        sck_n   = 1'b1;
        rx_n    = (rd_op && idx >= HDR) ? {rx[30:0], bus.spi_miso} : rx;
        state_n = SHIFT_HI;
      end
      SHIFT_HI: if (tick) begin
        sck_n = 1'b0;
        if (idx == bits - 7'd1) state_n = HOLD;
        else begin
          tx_n    = {tx[62:0], 1'b0};
          mosi_n  = tx[62];
          idx_n   = idx + 7'd1;
          state_n = SHIFT_LO;
        end
      end
      HOLD: if (tick) begin
        ss_n_n  = 1'b1;
        done_n  = 1'b1;
        rd_n    = (rd_op && bits != HDR) ? rx : rd;
        state_n = GAP;
      end
      GAP: if (tick) begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb_spi_cmd_sequencer: directed transactions against an SPI slave/monitor model
module tb_spi_cmd_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int rises = 0;
  int ss_low = 0;
  int dones = 0;
  logic [63:0] mosi_bits = '0;
  logic [63:0] miso_pat = '0;
  logic prev_sck = 1'b0;
  logic prev_ss = 1'b1;
  spi_cmd_sequencer_if bus ();
  spi_cmd_sequencer #(.CLK_DIV(2), .ADDR_BYTES(3)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  // slave model: counts per-transaction events and shifts miso on each sck rise
  always @(negedge clk) begin
    if (!bus.spi_ss_n && prev_ss) begin
      rises = 0;
      ss_low = 0;
      dones = 0;
      mosi_bits = '0;
    end
    if (!bus.spi_ss_n) ss_low++;
    if (bus.done) dones++;
    if (bus.spi_sck && !prev_sck) begin
      rises++;
      mosi_bits = {mosi_bits[62:0], bus.spi_mosi};
    end
    bus.spi_miso = rises < 64 ? miso_pat[63 - rises] : 1'b0;
    prev_sck = bus.spi_sck;
    prev_ss = bus.spi_ss_n;
  end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [7:0] op, input logic [23:0] ad, input logic [31:0] wd,
                    input logic [2:0] nb, input logic wr);
    bus.opcode = op;
    bus.addr = ad;
    bus.wr_data = wd;
    bus.nbytes = nb;
    bus.is_write = wr;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
  endtask
  task automatic wait_done();
    int n = 0;
    while (bus.done !== 1'b1 && n < 3000) begin
      step();
      n++;
    end
    chk("done_seen", n < 3000, 1);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    chk("idle_seen", n < 100, 1);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.opcode = '0;
    bus.addr = '0;
    bus.wr_data = '0;
    bus.nbytes = '0;
    bus.is_write = 1'b0;
    repeat (3) step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rd", bus.rd_data, 0);
    chk("rst_sck", bus.spi_sck, 0);
    chk("rst_mosi", bus.spi_mosi, 0);
    chk("rst_ss", bus.spi_ss_n, 1);
    rst = 1'b0;
    step();
    go(8'h06, 24'h0, 32'h0, 3'd0, 1'b1);
    chk("t1_ss_low_now", bus.spi_ss_n, 0);
    wait_done();
    chk("t1_rises", rises, 32);
    chk("t1_ss_low", ss_low, 132);
    chk("t1_mosi", mosi_bits, 64'h06000000);
    chk("t1_rd", bus.rd_data, 0);
    step();
    chk("t1_busy_gap", bus.busy, 1);
    chk("t1_done_1cyc", bus.done, 0);
    step();
    chk("t1_busy_fall", bus.busy, 0);
    chk("t1_dones", dones, 1);
    miso_pat = {32'h0, 32'hA5C33C5A};
    go(8'h03, 24'h000010, 32'hFFFFFFFF, 3'd4, 1'b0);
    wait_done();
    chk("t2_rd", bus.rd_data, 32'hA5C33C5A);
    chk("t2_mosi", mosi_bits, 64'h03000010_00000000);
    chk("t2_rises", rises, 64);
    wait_idle();
    go(8'h02, 24'h123456, 32'hDEADBEEF, 3'd2, 1'b1);
    wait_done();
    chk("t3_mosi", mosi_bits, 64'h0000_0212_3456_DEAD);
    chk("t3_rises", rises, 48);
    chk("t3_rd_kept", bus.rd_data, 32'hA5C33C5A);
    wait_idle();
    miso_pat = {32'h0, 32'hFFFFFFFF};
    go(8'h03, 24'h0, 32'h0, 3'd4, 1'b0);
    wait_done();
    chk("t4_rd_ff", bus.rd_data, 32'hFFFFFFFF);
    wait_idle();
    miso_pat = {32'h0, 8'h7E, 24'h0};
    go(8'h03, 24'h000100, 32'h0, 3'd1, 1'b0);
    wait_done();
    chk("t4_rd_7e", bus.rd_data, 32'h0000007E);
    chk("t4_rises_nb1", rises, 40);
    wait_idle();
    miso_pat = {32'h0, 32'h12345678};
    go(8'h03, 24'h000200, 32'h0, 3'd6, 1'b0);
    wait_done();
    chk("t4_rises_clamp", rises, 64);
    chk("t4_rd_clamp", bus.rd_data, 32'h12345678);
    wait_idle();
    go(8'h02, 24'hABCDEF, 32'h5A000000, 3'd1, 1'b1);
    repeat (30) step();
    bus.opcode = 8'hFF;
    bus.addr = 24'h0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done();
    chk("t5_mosi", mosi_bits, 64'h0000_0002_ABCD_EF5A);
    chk("t5_rises", rises, 40);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t5_busy_gap", bus.busy, 1);
    step();
    chk("t5_busy_low", bus.busy, 0);
    chk("t5_ss_high", bus.spi_ss_n, 1);
    chk("t5_dones", dones, 1);
    miso_pat = {32'h0, 16'hBEEF, 16'h0};
    go(8'h03, 24'h000300, 32'h0, 3'd2, 1'b0);
    wait_done();
    chk("t5_rd", bus.rd_data, 32'h0000BEEF);
    chk("t5_dones2", dones, 1);
    wait_idle();
    miso_pat = {32'h0, 32'hCAFEF00D};
    go(8'h03, 24'h000400, 32'h0, 3'd4, 1'b0);
    begin
      int n = 0;
      while (rises < 12 && n < 1000) begin
        step();
        n++;
      end
      chk("t6_addr_phase", n < 1000, 1);
    end
    rst = 1'b1;
    step();
    chk("t6_ss", bus.spi_ss_n, 1);
    chk("t6_sck", bus.spi_sck, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_rd", bus.rd_data, 0);
    chk("t6_done", bus.done, 0);
    chk("t6_dones", dones, 0);
    rst = 1'b0;
    step();
    go(8'h03, 24'h000400, 32'h0, 3'd4, 1'b0);
    wait_done();
    chk("t6_rd_after", bus.rd_data, 32'hCAFEF00D);
    chk("t6_rises_after", rises, 64);
    chk("t6_dones_after", dones, 1);
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
